// File: rtl/ipf_pkg.sv
// Shared types and defaults for the instruction prefetch unit.
// The optional perf counters are enabled with IPF_PERF_COUNTERS_EN.
package ipf_pkg;

   localparam int IPF_PC_W  = 7;
   localparam int IPF_DEPTH = 4;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } ipf_state_t;

   // One buffered word as seen by decode, for the default address width.
   typedef struct packed {
      logic [31:0]         instr;
      logic [IPF_PC_W-1:0] pc_inc;
   } ipf_entry_t;

endpackage

// File: rtl/ipf_fifo.sv
// Synchronous FIFO for assembled words: flush beats push/pop, head reads zero
// when empty, and count_nxt exposes the post-edge occupancy to the fetch control.
module ipf_fifo
   import ipf_pkg::*;
#(
   parameter int DEPTH = IPF_DEPTH,
   parameter int W     = $bits(ipf_entry_t)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] count_nxt
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Overflowing pushes and empty pops are dropped rather than corrupting pointers.
   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (do_push && !do_pop) begin
         count_nxt = count + CW'(1);
      end else if (!do_push && do_pop) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_prefetch_unit.sv
// Byte-serial instruction prefetch: assembles big-endian words into a FIFO for decode.
// Define IPF_PERF_COUNTERS_EN to add the perf_redirects / perf_starve counters.
module inst_prefetch_unit
   import ipf_pkg::*;
#(
   parameter int PC_W     = IPF_PC_W,
   parameter int DEPTH    = IPF_DEPTH,
   parameter int START_PC = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [PC_W-1:0]            imem_addr,
   input  logic [7:0]                 imem_rdata,
   input  logic                       redirect_valid,
   input  logic [PC_W-1:0]            redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [PC_W-1:0]            out_pc_inc,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef IPF_PERF_COUNTERS_EN
   ,
   output logic [15:0]                perf_redirects,
   output logic [15:0]                perf_starve
`endif
);

   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc_inc;
   } entry_t;

   ipf_state_t      state;
   ipf_state_t      state_n;
   logic            armed;
   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] fetch_pc_n;
   logic [1:0]      byte_idx;
   logic [1:0]      byte_idx_n;
   logic            pending;
   logic            pending_n;
   logic [PC_W-1:0] word_pc;
   logic [23:0]     asm_reg;
   logic            resp_valid;
   logic            resp_last;
   logic            push;
   logic            pop;
   logic            room;
   logic [CW-1:0]   count_nxt;
   entry_t          wr_entry;
   entry_t          head_entry;

   // The response to the 4th byte completes the word; a redirect kills it.
   assign push = resp_last && !redirect_valid;
   assign pop  = out_valid && out_ready && !redirect_valid;

   assign wr_entry.instr  = {asm_reg, imem_rdata};
   assign wr_entry.pc_inc = word_pc + PC_W'(4);

   ipf_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .wdata     (wr_entry),
      .head      (head_entry),
      .count     (fifo_count),
      .count_nxt (count_nxt)
   );

   assign out_valid  = (fifo_count != '0);
   assign out_instr  = head_entry.instr;
   assign out_pc_inc = head_entry.pc_inc;

   // Nothing is requested in the first cycle after reset.
   assign imem_req = armed && (state == FETCH);

   always_comb begin
      fetch_pc_n = fetch_pc;
      byte_idx_n = byte_idx;
      pending_n  = pending;
      if (redirect_valid) begin
         fetch_pc_n = redirect_pc;
         byte_idx_n = '0;
         pending_n  = 1'b0;
      end else begin
         if (push) begin
            pending_n = 1'b0;
         end
         if (imem_req) begin
            if (byte_idx == 2'd0) begin
               pending_n = 1'b1;
            end
            if (byte_idx == 2'd3) begin
               fetch_pc_n = fetch_pc + PC_W'(4);
               byte_idx_n = '0;
            end else begin
               byte_idx_n = byte_idx + 2'd1;
            end
         end
      end
   end

   // A new word may start only if it and any unfinished word fit beside what is
   // already buffered; a pop in the same cycle is not credited.
   assign room    = (int'(count_nxt) + int'(pending_n)) < DEPTH;
   assign state_n = ((byte_idx_n != 2'd0) || room) ? FETCH : HOLD;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         armed      <= 1'b0;
         fetch_pc   <= PC_W'(START_PC);
         byte_idx   <= '0;
         pending    <= 1'b0;
         word_pc    <= '0;
         asm_reg    <= '0;
         resp_valid <= 1'b0;
         resp_last  <= 1'b0;
         imem_addr  <= '0;
      end else begin
         state      <= state_n;
         armed      <= 1'b1;
         fetch_pc   <= fetch_pc_n;
         byte_idx   <= byte_idx_n;
         pending    <= pending_n;
         resp_valid <= imem_req && !redirect_valid;
         resp_last  <= imem_req && (byte_idx == 2'd3) && !redirect_valid;
         imem_addr  <= (state_n == FETCH) ? (fetch_pc_n + PC_W'(byte_idx_n)) : '0;
         if (imem_req && (byte_idx == 2'd0)) begin
            word_pc <= fetch_pc;
         end
         if (resp_valid) begin
            asm_reg <= {asm_reg[15:0], imem_rdata};
         end
      end
   end

`ifdef IPF_PERF_COUNTERS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_redirects <= '0;
         perf_starve    <= '0;
      end else begin
         if (redirect_valid && (perf_redirects != 16'hFFFF)) begin
            perf_redirects <= perf_redirects + 16'd1;
         end
         if (!out_valid && out_ready && (perf_starve != 16'hFFFF)) begin
            perf_starve <= perf_starve + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Bench for inst_prefetch_unit: word-stream reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_inst_prefetch_unit;

   localparam int PC_W     = 7;
   localparam int DEPTH    = 4;
   localparam int START_PC = 0;
   localparam int CW       = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            reset;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_rdata;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [PC_W-1:0] out_pc_inc;
   logic [CW-1:0]   fifo_count;
`ifdef IPF_PERF_COUNTERS_EN
   logic [15:0]     perf_redirects;
   logic [15:0]     perf_starve;
`endif

   inst_prefetch_unit #(
      .PC_W     (PC_W),
      .DEPTH    (DEPTH),
      .START_PC (START_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc_inc     (out_pc_inc),
      .fifo_count     (fifo_count)
`ifdef IPF_PERF_COUNTERS_EN
      ,
      .perf_redirects (perf_redirects),
      .perf_starve    (perf_starve)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- instruction memory ----------------
   logic [7:0] mem [128];

   function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
      logic [PC_W-1:0] a1, a2, a3;
      a1 = a + 7'd1;
      a2 = a + 7'd2;
      a3 = a + 7'd3;
      return {mem[a], mem[a1], mem[a2], mem[a3]};
   endfunction

   // Data answers a request one cycle later; idle cycles carry garbage.
   initial begin
      logic            r;
      logic [PC_W-1:0] a;
      imem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         r = imem_req;
         a = imem_addr;
         @(posedge clk);
         #1;
         imem_rdata = r ? mem[a] : 8'($urandom);
      end
   end

   // ---------------- reference model and compare process ----------------
   logic            armed = 1'b0;
   logic            post_reset = 1'b0;
   logic            post_redirect = 1'b0;
   logic [PC_W-1:0] redir_tgt;
   logic [PC_W-1:0] exp_pc;
   logic [PC_W-1:0] req_pc;
   int              req_k;
   int              started;
   int              popped;
   int              total_pops;
   logic            hold_prev = 1'b0;
   logic [31:0]     hold_instr;
   logic [PC_W-1:0] hold_pc;
   int              first_req_cyc = -1;
   int              first_valid_cyc = -1;
   logic [31:0]     first_valid_instr;
   logic [PC_W-1:0] first_valid_pc;
   logic [31:0]     pop_instr_q[$];
   logic [PC_W-1:0] pop_pc_q[$];
   int              pop_cyc_q[$];
   logic [15:0]     m_redirects;
   logic [15:0]     m_starve;

   always @(negedge clk) begin
      logic [PC_W-1:0] ea;
      if (armed) begin
         if (post_reset) begin
            check("rst_imem_req", imem_req, 0);
            check("rst_imem_addr", imem_addr, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_instr", out_instr, 0);
            check("rst_out_pc_inc", out_pc_inc, 0);
            check("rst_fifo_count", fifo_count, 0);
         end
         check("valid_vs_count", out_valid, fifo_count != 0);
         if (!out_valid) begin
            check("idle_instr_zero", out_instr, 0);
            check("idle_pc_zero", out_pc_inc, 0);
         end
         check("count_le_depth", fifo_count <= DEPTH, 1);
         if (post_redirect) begin
            check("redir_out_valid", out_valid, 0);
            check("redir_count", fifo_count, 0);
            check("redir_req", imem_req, 1);
            check("redir_addr", imem_addr, redir_tgt);
         end
         if (hold_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_instr", out_instr, hold_instr);
            check("stall_pc_inc", out_pc_inc, hold_pc);
         end
         if (imem_req) begin
            ea = req_pc + PC_W'(req_k);
            check("imem_addr", imem_addr, ea);
            if (req_k == 0) begin
               check("start_has_room", (started - popped + 1) <= DEPTH, 1);
               started++;
               if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            req_k++;
            if (req_k == 4) begin
               req_k = 0;
               req_pc = req_pc + PC_W'(4);
            end
         end
         if (out_valid && first_valid_cyc < 0) begin
            first_valid_cyc   = cyc;
            first_valid_instr = out_instr;
            first_valid_pc    = out_pc_inc;
         end
         if (out_valid && out_ready && !redirect_valid && !reset) begin
            ea = exp_pc + PC_W'(4);
            check("pop_instr", out_instr, word_at(exp_pc));
            check("pop_pc_inc", out_pc_inc, ea);
            pop_instr_q.push_back(out_instr);
            pop_pc_q.push_back(out_pc_inc);
            pop_cyc_q.push_back(cyc);
            exp_pc = ea;
            popped++;
            total_pops++;
         end
         hold_prev  = out_valid && !out_ready && !redirect_valid && !reset;
         hold_instr = out_instr;
         hold_pc    = out_pc_inc;
      end
      post_reset    = 1'b0;
      post_redirect = 1'b0;
      if (reset) begin
         armed       = 1'b1;
         post_reset  = 1'b1;
         exp_pc      = PC_W'(START_PC);
         req_pc      = PC_W'(START_PC);
         req_k       = 0;
         started     = 0;
         popped      = 0;
         hold_prev   = 1'b0;
         m_redirects = '0;
         m_starve    = '0;
      end else if (armed) begin
         if (redirect_valid) begin
            exp_pc        = redirect_pc;
            req_pc        = redirect_pc;
            redir_tgt     = redirect_pc;
            req_k         = 0;
            started       = 0;
            popped        = 0;
            post_redirect = 1'b1;
            hold_prev     = 1'b0;
            if (m_redirects != 16'hFFFF) m_redirects++;
         end
         if (!out_valid && out_ready && m_starve != 16'hFFFF) m_starve++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      first_req_cyc   = -1;
      first_valid_cyc = -1;
      pop_instr_q.delete();
      pop_pc_q.delete();
      pop_cyc_q.delete();
   endtask

   task automatic do_reset(input int n);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (pop_pc_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(name, pop_pc_q.size() >= n, 1);
   endtask

   task automatic pulse_redirect(input logic [PC_W-1:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   logic [PC_W-1:0] exp_q[$];

   initial begin
      int   k;
      logic found;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      total_pops     = 0;
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

      // first word latency and steady throughput
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      do_reset(2);
      out_ready = 1'b1;
      repeat (20) tick();
      check("t1_saw_request", first_req_cyc >= 0, 1);
      check("t1_latency", first_valid_cyc - first_req_cyc, 5);
      check("t1_instr", first_valid_instr, 32'h12345678);
      check("t1_pc_inc", first_valid_pc, 7'h04);
      check("t1_two_pops", pop_cyc_q.size() >= 2, 1);
      if (pop_cyc_q.size() >= 2) check("t1_throughput", pop_cyc_q[1] - pop_cyc_q[0], 4);

      // backpressure fills the FIFO and parks fetch
      out_ready = 1'b0;
      do_reset(2);
      k = 0;
      while (fifo_count != CW'(DEPTH) && k < 80) begin
         tick();
         k++;
      end
      check("t2_fill", fifo_count, DEPTH);
      repeat (6) begin
         tick();
         check("t2_hold_no_req", imem_req, 0);
         check("t2_hold_count", fifo_count, DEPTH);
      end
      exp_q = '{7'd4, 7'd8, 7'd12, 7'd16};
      out_ready = 1'b1;
      wait_pops(4, 40, "t2_drain");
      while (exp_q.size() > 0 && pop_pc_q.size() > 0) check("t2_order", pop_pc_q.pop_front(), exp_q.pop_front());

      // redirect mid-word with two words buffered
      mem[8'h20] = 8'hde; mem[8'h21] = 8'had; mem[8'h22] = 8'hbe; mem[8'h23] = 8'hef;
      out_ready = 1'b0;
      do_reset(2);
      found = 1'b0;
      k = 0;
      while (!found && k < 60) begin
         if (fifo_count == 2 && imem_req && req_k == 2) found = 1'b1;
         else begin
            tick();
            k++;
         end
      end
      check("t3_setup", found, 1);
      pulse_redirect(7'h20);
      check("t3_valid_low", out_valid, 0);
      check("t3_count_zero", fifo_count, 0);
      check("t3_req", imem_req, 1);
      check("t3_addr", imem_addr, 7'h20);
      clear_logs();
      out_ready = 1'b1;
      wait_pops(1, 20, "t3_pop");
      if (pop_pc_q.size() > 0) begin
         check("t3_instr", pop_instr_q[0], 32'hdeadbeef);
         check("t3_pc_inc", pop_pc_q[0], 7'h24);
      end

      // word straddling the top of memory
      mem[8'h7e] = 8'ha1; mem[8'h7f] = 8'hb2; mem[0] = 8'hc3; mem[1] = 8'hd4;
      do_reset(2);
      out_ready = 1'b1;
      repeat (3) tick();
      pulse_redirect(7'h7e);
      clear_logs();
      wait_pops(1, 20, "t4_pop");
      if (pop_pc_q.size() > 0) begin
         check("t4_instr", pop_instr_q[0], 32'ha1b2c3d4);
         check("t4_pc_inc", pop_pc_q[0], 7'h02);
      end

      // reset in the middle of a word with data buffered
      out_ready = 1'b0;
      do_reset(2);
      found = 1'b0;
      k = 0;
      while (!found && k < 60) begin
         if (fifo_count >= 1 && imem_req && req_k == 1) found = 1'b1;
         else begin
            tick();
            k++;
         end
      end
      check("t5_setup", found, 1);
      reset = 1'b1;
      mem[0] = 8'h0b; mem[1] = 8'had; mem[2] = 8'hf0; mem[3] = 8'h0d;
      tick();
      reset = 1'b0;
      check("t5_req", imem_req, 0);
      check("t5_valid", out_valid, 0);
      check("t5_instr", out_instr, 0);
      check("t5_pc_inc", out_pc_inc, 0);
      check("t5_count", fifo_count, 0);
      clear_logs();
      out_ready = 1'b1;
      wait_pops(1, 20, "t5_pop");
      if (pop_pc_q.size() > 0) begin
         check("t5_first_instr", pop_instr_q[0], 32'h0badf00d);
         check("t5_first_pc_inc", pop_pc_q[0], 7'h04);
      end

      // randomized traffic against the model
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      do_reset(2);
      total_pops = 0;
      for (int i = 0; i < 3000; i++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = PC_W'($urandom);
         reset          = ($urandom_range(0, 499) == 0);
         tick();
         clear_logs();
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      repeat (4) tick();
      check("rand_progress", total_pops >= 100, 1);
`ifdef IPF_PERF_COUNTERS_EN
      check("perf_redirects", perf_redirects, m_redirects);
      check("perf_starve", perf_starve, m_starve);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
- Fetch-side front end that feeds the IF/ID register of the 5-stage core.
- Reads a byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit words (byte at PC goes to bits 31:24).
- Buffers assembled words with their PC+4 in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush all buffered and in-flight fetch state.

Parameters:
- PC_W, 7, instruction address width (128-byte instruction memory).
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- START_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  byte read request this cycle.
- imem_addr  out  PC_W  byte address of the request.
- imem_rdata  in  8  read data, valid exactly 1 cycle after imem_req.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  PC_W  new fetch address, used as-is (no alignment forced).
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  decode accepts the head (IfId enable).
- out_instr  out  32  head instruction; 0 when out_valid=0.
- out_pc_inc  out  PC_W  head PC+4 mod 2^PC_W; 0 when out_valid=0.
- fifo_count  out  $clog2(DEPTH+1)  number of buffered words.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset state:
  - fetch_pc=START_PC, byte_idx=0, pending=0, FIFO empty.
  - Outputs: imem_req=0, imem_addr=0, out_valid=0, out_instr=0, out_pc_inc=0, fifo_count=0.
  - Asserting reset mid-word or mid-FIFO discards everything; no partial word survives.
- FSM states:
  - FETCH: issuing byte requests.
  - HOLD: FIFO has no reserved space.
  - Reset enters FETCH.
- In FETCH, each cycle:
  - imem_req=1, imem_addr=fetch_pc+byte_idx (mod 2^PC_W).
  - byte_idx increments 0..3.
  - On the byte_idx=3 request: fetch_pc+=4 (wraps), byte_idx returns to 0.
- Starting a new word (request with byte_idx=0):
  - Allowed only if fifo_count+pending < DEPTH. The same-cycle pop is ignored (conservative), so the FIFO never overflows.
  - pending=1 from the first request of a word until that word is pushed.
  - If not allowed, go to HOLD with imem_req=0.
  - Leave HOLD for FETCH on the cycle the condition becomes true; the request issues that same cycle.
- Assembly:
  - The response byte captured in cycle t+1 for a request in t is shifted into a 32-bit assembly register.
  - When the 4th byte is captured, push {b0,b1,b2,b3} with out_pc_inc = word_pc+4 and clear pending.
- Latency and throughput:
  - First request in cycle C gives out_valid=1 in cycle C+5.
  - Steady-state throughput is one word per 4 cycles.
- Handshake:
  - Pop on out_valid & out_ready.
  - Head data holds stable while out_valid=1 & out_ready=0.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop while empty is ignored.
- Redirect (highest priority, over push, pop and start):
  - At the edge: FIFO cleared, pending=0, byte_idx=0, fetch_pc=redirect_pc, state=FETCH.
  - Any response byte arriving in the next cycle belongs to the killed request and is dropped.
  - Cycle after redirect: out_valid=0 and imem_req=1 at redirect_pc.
  - Redirect on consecutive cycles: the last one wins.
- Wrap-around:
  - Byte addresses and fetch_pc wrap modulo 2^PC_W.
  - A word starting at 0x7E reads 0x7E, 0x7F, 0x00, 0x01.

Optional Feature:
- Macro: IPF_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_redirects[15:0] (count of redirect_valid cycles) and perf_starve[15:0] (cycles with out_valid=0 & out_ready=1).
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: the ports and logic are absent; core behaviour is identical.

Decomposition:
- Package ipf_pkg:
  - PC_W default constant.
  - State enum {FETCH, HOLD}.
  - Packed FIFO entry struct {instr[31:0], pc_inc[PC_W-1:0]}.
- Sub-module ipf_fifo:
  - Synchronous FIFO with push, pop, flush (flush dominant) and count.
  - Zero head output when empty.
- FSM, assembly and address logic stay in the top.

Test Plan:
- Reset, imem[0..3]=12 34 56 78, out_ready=1 → out_valid first at cycle C+5 with out_instr=0x12345678, out_pc_inc=4.
- out_ready=0, DEPTH=4, sequential words → fifo_count reaches 4, imem_req=0 (HOLD), no word lost. Then out_ready=1 → words pop in order, pc_inc 4, 8, 12, 16.
- Redirect to 0x20 while byte_idx=2 with FIFO holding 2 words → next cycle out_valid=0, fifo_count=0, imem_addr=0x20; next word out is imem[0x20..0x23] with pc_inc 0x24.
- Redirect to 0x7E → out_instr={imem[7E],imem[7F],imem[00],imem[01]}, out_pc_inc=0x02.
- Reset asserted mid-assembly with FIFO non-empty → next cycle all outputs 0, fetch restarts at START_PC, no stale word emitted.
- With IPF_PERF_COUNTERS_EN: 3 redirects plus 10 starved cycles → perf_redirects=3, perf_starve=10; preloaded near saturation, stays at 0xFFFF.
